// File: rtl/pa_cpu_pkg.sv
// Shared types for the CPU/DMA bus cycle arbiter: bus widths, FSM states,
// owner encoding and the latched command payload.
package pa_cpu;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              wr;
    logic              mem_io;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Round-robin pick: on a tie the requester that did not own the last cycle wins.
  function automatic owner_t pick_owner(input logic cpu_req, input logic dma_req,
                                        input owner_t last_owner);
    if (cpu_req && dma_req) begin
      return (last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
    end else if (dma_req) begin
      return OWNER_DMA;
    end
    return OWNER_CPU;
  endfunction

endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// Requester and external bus signals of the bus cycle arbiter.
// master: the arbiter itself; slave: the requesters / external bus model.
interface bus_cycle_arbiter_if;
  import pa_cpu::*;

  logic              cpu_req;
  logic              cpu_wr;
  logic              cpu_mem_io;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req;
  logic              dma_wr;
  logic              dma_mem_io;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              pin_wait;
  logic [DATA_W-1:0] data_in;

  logic [ADDR_W-1:0] address_bus;
  logic              mem_io;
  logic              rd_n;
  logic              wr_n;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              cpu_done;
  logic              dma_done;
  logic [DATA_W-1:0] rdata;
  logic              dma_gnt;
  logic              busy;

  modport master (
    input  cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_mem_io, dma_addr, dma_wdata,
    input  pin_wait, data_in,
    output address_bus, mem_io, rd_n, wr_n, data_out, data_oe,
    output cpu_done, dma_done, rdata, dma_gnt, busy
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_mem_io, dma_addr, dma_wdata,
    output pin_wait, data_in,
    input  address_bus, mem_io, rd_n, wr_n, data_out, data_oe,
    input  cpu_done, dma_done, rdata, dma_gnt, busy
  );

endinterface

// File: rtl/bus_cycle_arbiter.sv
// Two-requester (CPU/DMA) external bus cycle sequencer: IDLE -> SETUP ->
// STROBE (WAIT_CYCLES+1 minimum, stretched by pin_wait) -> HOLD, all outputs registered.
module bus_cycle_arbiter
  import pa_cpu::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                arst,
  bus_cycle_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  bus_state_t       r_state;
  owner_t           r_owner;
  owner_t           r_last_owner;
  logic             r_wr;
  logic [CNT_W-1:0] r_cnt;

  logic     w_any_req;
  owner_t   w_winner;
  bus_cmd_t w_cmd;

  assign w_any_req = bus.cpu_req | bus.dma_req;
  assign w_winner  = pick_owner(bus.cpu_req, bus.dma_req, r_last_owner);

  // Command of the requester that wins arbitration this cycle.
  always_comb begin
    w_cmd = '0;
    if (w_winner == OWNER_DMA) begin
      w_cmd = {bus.dma_wr, bus.dma_mem_io, bus.dma_addr, bus.dma_wdata};
    end else begin
      w_cmd = {bus.cpu_wr, bus.cpu_mem_io, bus.cpu_addr, bus.cpu_wdata};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWNER_CPU;
      r_last_owner    <= OWNER_DMA;
      r_wr            <= 1'b0;
      r_cnt           <= '0;
      bus.address_bus <= '0;
      bus.mem_io      <= 1'b1;
      bus.rd_n        <= 1'b1;
      bus.wr_n        <= 1'b1;
      bus.data_out    <= '0;
      bus.data_oe     <= 1'b0;
      bus.cpu_done    <= 1'b0;
      bus.dma_done    <= 1'b0;
      bus.rdata       <= '0;
      bus.dma_gnt     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.dma_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state         <= ST_SETUP;
            r_owner         <= w_winner;
            r_wr            <= w_cmd.wr;
            bus.address_bus <= w_cmd.addr;
            bus.mem_io      <= w_cmd.mem_io;
            bus.data_out    <= w_cmd.wdata;
            bus.data_oe     <= w_cmd.wr;
            bus.dma_gnt     <= (w_winner == OWNER_DMA);
            bus.busy        <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state  <= ST_STROBE;
          r_cnt    <= WAIT_LOAD;
          bus.rd_n <= r_wr;
          bus.wr_n <= ~r_wr;
        end
        ST_STROBE: begin
          // Leave only once the programmed wait has elapsed and the pin releases.
          if ((r_cnt == '0) && !bus.pin_wait) begin
            r_state      <= ST_HOLD;
            bus.rd_n     <= 1'b1;
            bus.wr_n     <= 1'b1;
            r_last_owner <= r_owner;
            bus.cpu_done <= (r_owner == OWNER_CPU);
            bus.dma_done <= (r_owner == OWNER_DMA);
            if (!r_wr) begin
              bus.rdata <= bus.data_in;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          r_state     <= ST_IDLE;
          bus.data_oe <= 1'b0;
          bus.dma_gnt <= 1'b0;
          bus.busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Scoreboard bench for bus_cycle_arbiter: a WAIT_CYCLES=1 instance for the main
// sequences and a WAIT_CYCLES=0 instance for the zero-wait IO read.
module tb_bus_cycle_arbiter;
  import pa_cpu::*;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  always #5 clk = ~clk;

  bus_cycle_arbiter_if a_if ();
  bus_cycle_arbiter_if b_if ();

  bus_cycle_arbiter #(.WAIT_CYCLES(1)) u_dut  (.clk(clk), .arst(arst), .bus(a_if));
  bus_cycle_arbiter #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .arst(arst), .bus(b_if));

  typedef struct {
    logic        owner;
    logic        wr;
    logic        mem_io;
    logic [21:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];
  int   done_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rd_low, wr_low, oe_cnt, gnt_cnt, cpu_dn, dma_dn;
  int   dual_low = 0;
  int   req_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    rd_low = 0; wr_low = 0; oe_cnt = 0; gnt_cnt = 0; cpu_dn = 0; dma_dn = 0;
    done_cyc.delete();
  endtask

  // Per-cycle monitor on the main instance; pops the scoreboard on each done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (!a_if.rd_n) rd_low++;
    if (!a_if.wr_n) wr_low++;
    if (a_if.data_oe) oe_cnt++;
    if (a_if.dma_gnt) gnt_cnt++;
    if (!a_if.rd_n && !a_if.wr_n) dual_low++;
    if (a_if.cpu_done || a_if.dma_done) begin
      done_cyc.push_back(cyc);
      if (a_if.cpu_done) cpu_dn++;
      if (a_if.dma_done) dma_dn++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_single_done", 32'(a_if.cpu_done ^ a_if.dma_done), 32'(1));
        chk("sb_owner", 32'(a_if.dma_done), 32'(e.owner));
        chk("sb_addr", 32'(a_if.address_bus), 32'(e.addr));
        chk("sb_mem_io", 32'(a_if.mem_io), 32'(e.mem_io));
        if (e.wr) chk("sb_wdata", 32'(a_if.data_out), 32'(e.data));
        else      chk("sb_rdata", 32'(a_if.rdata), 32'(e.data));
      end
    end
  end

  task automatic zero_inputs();
    a_if.cpu_req = 0; a_if.cpu_wr = 0; a_if.cpu_mem_io = 1; a_if.cpu_addr = '0; a_if.cpu_wdata = '0;
    a_if.dma_req = 0; a_if.dma_wr = 0; a_if.dma_mem_io = 1; a_if.dma_addr = '0; a_if.dma_wdata = '0;
    a_if.pin_wait = 0; a_if.data_in = '0;
    b_if.cpu_req = 0; b_if.cpu_wr = 0; b_if.cpu_mem_io = 1; b_if.cpu_addr = '0; b_if.cpu_wdata = '0;
    b_if.dma_req = 0; b_if.dma_wr = 0; b_if.dma_mem_io = 1; b_if.dma_addr = '0; b_if.dma_wdata = '0;
    b_if.pin_wait = 0; b_if.data_in = '0;
  endtask

  initial begin
    zero_inputs();
    clr();
    repeat (2) tick();

    // Reset state
    chk("rst_rd_n", 32'(a_if.rd_n), 32'(1));
    chk("rst_wr_n", 32'(a_if.wr_n), 32'(1));
    chk("rst_data_oe", 32'(a_if.data_oe), 32'(0));
    chk("rst_addr", 32'(a_if.address_bus), 32'(0));
    chk("rst_data_out", 32'(a_if.data_out), 32'(0));
    chk("rst_mem_io", 32'(a_if.mem_io), 32'(1));
    chk("rst_rdata", 32'(a_if.rdata), 32'(0));
    chk("rst_flags", 32'({a_if.cpu_done, a_if.dma_done, a_if.dma_gnt, a_if.busy}), 32'(0));
    chk("rst0_mem_io", 32'(b_if.mem_io), 32'(1));
    arst = 0;
    tick();

    // CPU memory read, WAIT_CYCLES=1; request dropped and address changed after latching
    clr();
    a_if.cpu_req = 1; a_if.cpu_wr = 0; a_if.cpu_mem_io = 1;
    a_if.cpu_addr = 22'h12345; a_if.data_in = 8'hA5;
    sb_q.push_back('{1'b0, 1'b0, 1'b1, 22'h12345, 8'hA5});
    req_cyc = cyc;
    tick();
    chk("t1_setup_busy", 32'(a_if.busy), 32'(1));
    chk("t1_setup_strobes", 32'({a_if.rd_n, a_if.wr_n}), 32'(2'b11));
    chk("t1_setup_addr", 32'(a_if.address_bus), 32'h12345);
    chk("t1_setup_oe", 32'(a_if.data_oe), 32'(0));
    chk("t1_setup_gnt", 32'(a_if.dma_gnt), 32'(0));
    a_if.cpu_req = 0; a_if.cpu_addr = 22'h3FFFF;
    repeat (4) tick();
    chk("t1_rd_low", 32'(rd_low), 32'(2));
    chk("t1_wr_low", 32'(wr_low), 32'(0));
    chk("t1_cpu_done_cnt", 32'(cpu_dn), 32'(1));
    chk("t1_done_events", 32'(done_cyc.size()), 32'(1));
    if (done_cyc.size() > 0) chk("t1_latency", 32'(done_cyc[0] - req_cyc), 32'(4));
    chk("t1_rdata", 32'(a_if.rdata), 32'hA5);
    chk("t1_idle_busy", 32'(a_if.busy), 32'(0));

    // DMA write with pin_wait adding three strobe cycles
    clr();
    a_if.dma_req = 1; a_if.dma_wr = 1; a_if.dma_mem_io = 1;
    a_if.dma_addr = 22'h00100; a_if.dma_wdata = 8'h3C;
    a_if.pin_wait = 1; a_if.data_in = 8'h11;
    sb_q.push_back('{1'b1, 1'b1, 1'b1, 22'h00100, 8'h3C});
    tick();
    chk("t2_setup_oe", 32'(a_if.data_oe), 32'(1));
    chk("t2_setup_gnt", 32'(a_if.dma_gnt), 32'(1));
    chk("t2_setup_data", 32'(a_if.data_out), 32'h3C);
    a_if.dma_req = 0;
    repeat (5) tick();
    a_if.pin_wait = 0;
    repeat (2) tick();
    chk("t2_wr_low", 32'(wr_low), 32'(5));
    chk("t2_rd_low", 32'(rd_low), 32'(0));
    chk("t2_oe_cycles", 32'(oe_cnt), 32'(7));
    chk("t2_gnt_cycles", 32'(gnt_cnt), 32'(7));
    chk("t2_dma_done_cnt", 32'(dma_dn), 32'(1));
    chk("t2_cpu_done_cnt", 32'(cpu_dn), 32'(0));
    chk("t2_rdata_held", 32'(a_if.rdata), 32'hA5);

    // Both requesters held from reset: CPU, DMA, CPU, DMA, done every 5 cycles
    arst = 1;
    a_if.cpu_req = 1; a_if.cpu_wr = 0; a_if.cpu_mem_io = 1; a_if.cpu_addr = 22'h0AAAA;
    a_if.dma_req = 1; a_if.dma_wr = 1; a_if.dma_mem_io = 0; a_if.dma_addr = 22'h15555;
    a_if.dma_wdata = 8'h77; a_if.data_in = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{1'b0, 1'b0, 1'b1, 22'h0AAAA, 8'h5A});
      sb_q.push_back('{1'b1, 1'b1, 1'b0, 22'h15555, 8'h77});
    end
    tick();
    chk("t3_reset_rdata", 32'(a_if.rdata), 32'(0));
    clr();
    arst = 0;
    repeat (19) tick();
    a_if.cpu_req = 0; a_if.dma_req = 0;
    repeat (3) tick();
    chk("t3_cpu_dones", 32'(cpu_dn), 32'(2));
    chk("t3_dma_dones", 32'(dma_dn), 32'(2));
    chk("t3_done_events", 32'(done_cyc.size()), 32'(4));
    for (int i = 1; i < done_cyc.size(); i++)
      chk("t3_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(5));

    // Reset asserted during STROBE aborts the cycle; a fresh one follows release
    clr();
    a_if.cpu_req = 1; a_if.cpu_wr = 1; a_if.cpu_mem_io = 1;
    a_if.cpu_addr = 22'h2AAAA; a_if.cpu_wdata = 8'h99;
    tick();
    tick();
    chk("t4_strobe_low", 32'(a_if.wr_n), 32'(0));
    #1 arst = 1;
    #1;
    chk("t4_abort_strobes", 32'({a_if.rd_n, a_if.wr_n}), 32'(2'b11));
    chk("t4_abort_busy", 32'(a_if.busy), 32'(0));
    chk("t4_abort_oe", 32'(a_if.data_oe), 32'(0));
    chk("t4_abort_addr", 32'(a_if.address_bus), 32'(0));
    tick();
    chk("t4_no_done", 32'(cpu_dn + dma_dn), 32'(0));
    arst = 0;
    sb_q.push_back('{1'b0, 1'b1, 1'b1, 22'h2AAAA, 8'h99});
    repeat (2) tick();
    a_if.cpu_req = 0;
    repeat (4) tick();
    chk("t4_fresh_done", 32'(cpu_dn), 32'(1));
    chk("t4_wr_low", 32'(wr_low), 32'(3));

    // WAIT_CYCLES=0 IO read on the second instance
    b_if.cpu_req = 1; b_if.cpu_wr = 0; b_if.cpu_mem_io = 0;
    b_if.cpu_addr = 22'h3FFFF; b_if.data_in = 8'hC3;
    tick();
    chk("t5_setup_mem_io", 32'(b_if.mem_io), 32'(0));
    chk("t5_setup_addr", 32'(b_if.address_bus), 32'h3FFFF);
    chk("t5_setup_rd_n", 32'(b_if.rd_n), 32'(1));
    b_if.cpu_req = 0;
    tick();
    chk("t5_strobe_rd_n", 32'(b_if.rd_n), 32'(0));
    tick();
    chk("t5_hold_rd_n", 32'(b_if.rd_n), 32'(1));
    chk("t5_done_n3", 32'(b_if.cpu_done), 32'(1));
    chk("t5_rdata", 32'(b_if.rdata), 32'hC3);
    tick();
    chk("t5_done_pulse", 32'(b_if.cpu_done), 32'(0));
    chk("t5_idle_busy", 32'(b_if.busy), 32'(0));

    chk("no_dual_strobe", 32'(dual_low), 32'(0));
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_cycle_arbiter.md
BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

Interface
- REQ-001 Parameter WAIT_CYCLES, default 1, is the number of extra strobe cycles per bus cycle (range 0..15).
- REQ-002 clk  in  1  system clock; all state changes on the rising edge.
- REQ-003 arst  in  1  reset, asynchronous, active-high.
- REQ-004 cpu_req, cpu_wr, cpu_mem_io  in  1 each  CPU cycle request, write (1) or read (0), memory (1) or IO (0).
- REQ-005 cpu_addr  in  22 and cpu_wdata  in  8  CPU address and write data.
- REQ-006 dma_req, dma_wr, dma_mem_io  in  1 each; dma_addr  in  22; dma_wdata  in  8  DMA requester equivalents.
- REQ-007 pin_wait  in  1  external wait; 1 stretches the strobe.
- REQ-008 data_in  in  8  sampled external data bus.
- REQ-009 address_bus  out  22; mem_io  out  1; rd_n, wr_n  out  1 each (active-low strobes).
- REQ-010 data_out  out  8 and data_oe  out  1  write data and its drive enable.
- REQ-011 cpu_done, dma_done  out  1 each  single-cycle completion pulses.
- REQ-012 rdata  out  8  read data; dma_gnt  out  1  DMA owns the current cycle; busy  out  1  state is not IDLE.

Function
- REQ-013 The FSM SHALL have the states IDLE, SETUP, STROBE and HOLD.
- REQ-014 IDLE: with any request present, latch the winner's wr/mem_io/addr/wdata, go to SETUP; otherwise stay.
- REQ-015 Arbitration is round-robin via last_owner: both requesting grants the non-last owner; a single requester always wins.
- REQ-016 SETUP (1 cycle): address_bus/mem_io driven from the latched values; rd_n=wr_n=1; data_oe=wr.
- REQ-017 STROBE: rd_n=0 (read) or wr_n=0 (write); 4-bit counter loaded with WAIT_CYCLES on SETUP exit, decremented each STROBE cycle.
- REQ-018 STROBE exits to HOLD when counter==0 and pin_wait==0; otherwise it stays, so the minimum is WAIT_CYCLES+1 cycles and pin_wait can stretch it indefinitely.
- REQ-019 Reads: rdata captures data_in on the STROBE exit edge and holds until the next read completes.
- REQ-020 HOLD (1 cycle): strobes high, address and data_oe held; the owner's done pulses; last_owner updated; next state IDLE.
- REQ-021 Latency: request in IDLE at cycle N gives SETUP at N+1, STROBE N+2..N+2+WAIT_CYCLES, done at N+3+WAIT_CYCLES.
- REQ-022 Back-to-back: a request held through done starts a new cycle at the IDLE following HOLD; there is no combinational IDLE bypass.
- REQ-023 Requests dropped or changed after latching are ignored; the latched cycle always completes.
- REQ-024 dma_gnt is 1 from SETUP through HOLD of a DMA-owned cycle, else 0.
- REQ-025 rd_n and wr_n are never low simultaneously; strobes and data_oe are registered outputs (glitch-free).

Reset
- REQ-026 While arst=1: state=IDLE, rd_n=wr_n=1, data_oe=0, address_bus=0, data_out=0, mem_io=1, rdata=0, all done/dma_gnt/busy=0, counter=0, last_owner=DMA (CPU wins first tie).
- REQ-027 Reset mid-cycle aborts immediately; no done pulse is issued for the aborted cycle.

Structure
- REQ-028 bus_state_t (enum) and the owner encoding live in package pa_cpu; WAIT_CYCLES stays a module parameter.
- REQ-029 The block is a single module with no sub-module; the arbiter is inline logic.

Verification
- REQ-030 CPU read, addr 0x12345, WAIT_CYCLES=1, data_in=0xA5 -> rd_n low 2 cycles, cpu_done at N+4, rdata=0xA5.
- REQ-031 DMA write 0x3C to 0x00100, pin_wait high 3 extra cycles -> wr_n low 5 cycles, data_oe=1 SETUP..HOLD, dma_gnt=1, dma_done once.
- REQ-032 cpu_req and dma_req held continuously from reset -> grants alternate CPU, DMA, CPU, DMA; each done spaced 5 cycles apart.
- REQ-033 arst pulsed during STROBE -> strobes high the same cycle, no done, and a fresh cycle runs after release.
- REQ-034 WAIT_CYCLES=0, mem_io=0 read -> strobe 1 cycle, mem_io=0 on the bus, done at N+3.
